// File: rtl/hdmi_pattern_gen.sv
// rtl/hdmi_pattern_gen.sv - raster timing generator with selectable video test patterns
//
// Produces a continuous video raster (active, front porch, sync, back porch on
// both axes) and fills the active area with one of four test patterns.
// The pattern is chosen once per frame so a frame never mixes patterns.
//
// Ports
//   hdmi_clk     in   pixel clock, all logic on the rising edge
//   rst          in   synchronous reset, active-high
//   en           in   1 = generate frames, 0 = stop after the current frame
//   pattern_sel  in   0 bars, 1 gradient, 2 checker, 3 solid
//   hdmi_hs      out  horizontal sync, active-low
//   hdmi_vs      out  vertical sync, active-low
//   hdmi_de      out  data enable, high on active pixels only
//   hdmi_data    out  {8'h00, R, G, B}, zero outside the active area
//   frame_cnt    out  completed-frame counter, wraps 255 -> 0

module hdmi_pattern_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20
) (
    input  logic        hdmi_clk,
    input  logic        rst,
    input  logic        en,
    input  logic [1:0]  pattern_sel,
    output logic        hdmi_hs,
    output logic        hdmi_vs,
    output logic        hdmi_de,
    output logic [31:0] hdmi_data,
    output logic [7:0]  frame_cnt
);
    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BAR_W = H_ACTIVE / 8;

    localparam logic [15:0] H_ACT_C  = 16'(H_ACTIVE);
    localparam logic [15:0] H_SYNC_S = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] H_SYNC_E = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0] H_LAST   = 16'(H_TOT - 1);
    localparam logic [15:0] V_ACT_C  = 16'(V_ACTIVE);
    localparam logic [15:0] V_SYNC_S = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] V_SYNC_E = 16'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [15:0] V_LAST   = 16'(V_TOT - 1);
    localparam logic [15:0] BAR_LAST = 16'(BAR_W - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [15:0] h_q, h_d, v_q, v_d;
    logic [15:0] bar_px_q, bar_px_d;
    logic [2:0]  bar_idx_q, bar_idx_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [1:0]  pat_q, pat_d;
    logic        hs_q, hs_d, vs_q, vs_d, de_q, de_d;
    logic [31:0] data_q, data_d;
    logic        active, line_end, frame_end;
    logic [23:0] rgb;

    assign active    = (state_q != IDLE);
    assign line_end  = (h_q == H_LAST);
    assign frame_end = active && line_end && (v_q == V_LAST);

    always_ff @(posedge hdmi_clk) begin
        if (rst) begin
            state_q     <= IDLE;
            h_q         <= '0;
            v_q         <= '0;
            bar_px_q    <= '0;
            bar_idx_q   <= '0;
            frame_cnt_q <= '0;
            pat_q       <= '0;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            de_q        <= 1'b0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            v_q         <= v_d;
            bar_px_q    <= bar_px_d;
            bar_idx_q   <= bar_idx_d;
            frame_cnt_q <= frame_cnt_d;
            pat_q       <= pat_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            de_q        <= de_d;
            data_q      <= data_d;
        end
    end

    // Dropping en on the very last pixel already completes the frame, so go
    // straight to IDLE rather than draining a whole extra frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en) state_d = RUN;
            RUN:     if (!en) state_d = frame_end ? IDLE : DRAIN;
            DRAIN: begin
                if (en)             state_d = RUN;
                else if (frame_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Raster counters, bar tracker, frame counter and per-frame pattern latch.
    // The bar index follows h with a small pixel counter so no divider is needed.
    always_comb begin
        h_d         = h_q;
        v_d         = v_q;
        bar_px_d    = bar_px_q;
        bar_idx_d   = bar_idx_q;
        frame_cnt_d = frame_cnt_q;
        pat_d       = pat_q;
        if (!active) begin
            h_d       = '0;
            v_d       = '0;
            bar_px_d  = '0;
            bar_idx_d = '0;
            if (en) pat_d = pattern_sel;
        end else begin
            if (line_end) begin
                h_d       = '0;
                bar_px_d  = '0;
                bar_idx_d = '0;
                v_d       = (v_q == V_LAST) ? 16'd0 : v_q + 16'd1;
            end else begin
                h_d = h_q + 16'd1;
                if (bar_px_q == BAR_LAST) begin
                    bar_px_d  = '0;
                    bar_idx_d = bar_idx_q + 3'd1;
                end else begin
                    bar_px_d  = bar_px_q + 16'd1;
                end
            end
            if (frame_end) begin
                frame_cnt_d = frame_cnt_q + 8'd1;
                pat_d       = pattern_sel;
            end
        end
    end

    // Registered outputs reflect the counter state of the previous cycle.
    always_comb begin
        rgb = 24'h000000;
        case (pat_q)
            2'd0: begin
                case (bar_idx_q)
                    3'd0:    rgb = 24'hFFFFFF;
                    3'd1:    rgb = 24'hFFFF00;
                    3'd2:    rgb = 24'h00FFFF;
                    3'd3:    rgb = 24'h00FF00;
                    3'd4:    rgb = 24'hFF00FF;
                    3'd5:    rgb = 24'hFF0000;
                    3'd6:    rgb = 24'h0000FF;
                    default: rgb = 24'h000000;
                endcase
            end
            2'd1:    rgb = {h_q[7:0], v_q[7:0], frame_cnt_q};
            2'd2:    rgb = (h_q[5] ^ v_q[5]) ? 24'hFFFFFF : 24'h000000;
            default: rgb = {frame_cnt_q, ~frame_cnt_q, 8'h80};
        endcase

        hs_d   = 1'b1;
        vs_d   = 1'b1;
        de_d   = 1'b0;
        data_d = '0;
        if (active) begin
            hs_d = !((h_q >= H_SYNC_S) && (h_q < H_SYNC_E));
            vs_d = !((v_q >= V_SYNC_S) && (v_q < V_SYNC_E));
            de_d = (h_q < H_ACT_C) && (v_q < V_ACT_C);
            if (de_d) data_d = {8'h00, rgb};
        end
    end

    assign hdmi_hs   = hs_q;
    assign hdmi_vs   = vs_q;
    assign hdmi_de   = de_q;
    assign hdmi_data = data_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_hdmi_pattern_gen.sv
// tb/tb_hdmi_pattern_gen.sv - self-checking bench for hdmi_pattern_gen on a small raster
module tb_hdmi_pattern_gen;
    localparam int HA = 64, HF = 4, HS = 4, HB = 8, HT = 80;
    localparam int VA = 64, VF = 2, VS = 2, VB = 4, VT = 72;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst, en;
    logic [1:0]  sel;
    logic        hs, vs, de;
    logic [31:0] data;
    logic [7:0]  fcnt;

    int checks = 0, errors = 0, cyc = 0;
    logic [31:0] sb_q[$];
    logic [31:0] exp_v;
    logic        mon_on = 1'b0;
    int de_total = 0, hs_low_total = 0, vs_low_total = 0;
    int de_rise_n = 0, de_rise_cyc = 0, hs_fall_n = 0, hs_fall_cyc = 0, vs_fall_n = 0, vs_fall_cyc = 0;
    logic de_p = 1'b0, hs_p = 1'b1, vs_p = 1'b1;

    always #5 clk = ~clk;

    hdmi_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .hdmi_clk(clk), .rst(rst), .en(en), .pattern_sel(sel),
        .hdmi_hs(hs), .hdmi_vs(vs), .hdmi_de(de), .hdmi_data(data), .frame_cnt(fcnt)
    );

    function automatic logic [31:0] exp_pix(input logic [1:0] s, input int x, input int y, input logic [7:0] fc);
        logic [23:0] c;
        case (s)
            2'd0: begin
                case (x / (HA / 8))
                    0: c = 24'hFFFFFF;
                    1: c = 24'hFFFF00;
                    2: c = 24'h00FFFF;
                    3: c = 24'h00FF00;
                    4: c = 24'hFF00FF;
                    5: c = 24'hFF0000;
                    6: c = 24'h0000FF;
                    default: c = 24'h000000;
                endcase
            end
            2'd1: c = {8'(x), 8'(y), fc};
            2'd2: c = ((((x / 32) ^ (y / 32)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
            default: c = {fc, ~fc, 8'h80};
        endcase
        return {8'h00, c};
    endfunction

    task automatic push_frame(input logic [1:0] s, input logic [7:0] fc);
        for (int y = 0; y < VA; y++)
            for (int x = 0; x < HA; x++)
                sb_q.push_back(exp_pix(s, x, y, fc));
    endtask

    // Monitor: scoreboard pop on every active pixel, plus sync/enable statistics.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (mon_on) begin
            if (de === 1'b1) begin
                de_total++;
                if (de_p !== 1'b1) begin de_rise_n++; de_rise_cyc = cyc; end
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_de cyc=%0d got data=%h expected no active pixel", cyc, data);
                end else begin
                    exp_v = sb_q.pop_front();
                    if (data !== exp_v) begin
                        errors++;
                        $display("FAIL sb_pixel cyc=%0d got=%h expected=%h", cyc, data, exp_v);
                    end
                end
            end else begin
                checks++;
                if (data !== 32'h0) begin
                    errors++;
                    $display("FAIL blank_data cyc=%0d got=%h expected=00000000", cyc, data);
                end
            end
            if (hs === 1'b0) hs_low_total++;
            if (hs_p === 1'b1 && hs === 1'b0) begin hs_fall_n++; hs_fall_cyc = cyc; end
            if (vs === 1'b0) vs_low_total++;
            if (vs_p === 1'b1 && vs === 1'b0) begin vs_fall_n++; vs_fall_cyc = cyc; end
        end
        de_p = de;
        hs_p = hs;
        vs_p = vs;
    end

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) step();
    endtask

    task automatic wait_de_rise(input int n0, input int limit, output int c);
        int t0;
        t0 = cyc;
        while (de_rise_n == n0 && cyc < t0 + limit) step();
        c = de_rise_cyc;
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b0; sel = 2'd0;
        sb_q.delete();
        repeat (3) step();
        mon_on = 1'b1;
        checks++;
        if (hs !== 1'b1 || vs !== 1'b1 || de !== 1'b0 || data !== 32'h0 || fcnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_idle got hs=%b vs=%b de=%b data=%h fcnt=%0d expected 1 1 0 0 0", hs, vs, de, data, fcnt);
        end
        rst = 1'b0;
        repeat (20) step();
        checks++;
        if (de_total != 0 || de !== 1'b0 || hs !== 1'b1 || vs !== 1'b1) begin
            errors++;
            $display("FAIL idle_no_en got de_total=%0d de=%b hs=%b vs=%b expected 0 0 1 1", de_total, de, hs, vs);
        end
    endtask

    task automatic test_bars;
        int cen, fd, n0, h0, v0, s_de, s_hs, s_vs;
        sel = 2'd0;
        push_frame(2'd0, 8'd0);
        n0 = de_rise_n; h0 = hs_fall_n; v0 = vs_fall_n;
        en = 1'b1; cen = cyc;
        wait_de_rise(n0, 20, fd);
        checks++;
        if (fd - cen != 2) begin
            errors++;
            $display("FAIL first_de_latency got=%0d expected=2", fd - cen);
        end
        s_de = de_total; s_hs = hs_low_total; s_vs = vs_low_total;
        checks++;
        if (data !== 32'h00FFFFFF) begin errors++; $display("FAIL bar_x0 got=%h expected=00FFFFFF", data); end
        wait_cyc(fd + 8);
        checks++;
        if (data !== 32'h00FFFF00) begin errors++; $display("FAIL bar_x8 got=%h expected=00FFFF00", data); end
        wait_cyc(fd + 63);
        checks++;
        if (data !== 32'h00000000 || de !== 1'b1) begin errors++; $display("FAIL bar_x63 got data=%h de=%b expected 00000000 1", data, de); end
        wait_cyc(fd + HT);
        checks++;
        if (hs_fall_n != h0 + 1 || hs_fall_cyc - fd != 68 || hs_low_total - s_hs != 4) begin
            errors++;
            $display("FAIL hs_line0 got falls=%0d offset=%0d low=%0d expected 1 68 4", hs_fall_n - h0, hs_fall_cyc - fd, hs_low_total - s_hs);
        end
        push_frame(2'd0, 8'd1);
        wait_cyc(fd + 66 * HT);
        checks++;
        if (vs_fall_n != v0 + 1 || vs_fall_cyc != fd + 66 * HT) begin
            errors++;
            $display("FAIL vs_fall got falls=%0d offset=%0d expected 1 %0d", vs_fall_n - v0, vs_fall_cyc - fd, 66 * HT);
        end
        wait_cyc(fd + FRAME);
        checks++;
        if (de_total - s_de != VA * HA || hs_low_total - s_hs != VT * HS || vs_low_total - s_vs != VS * HT) begin
            errors++;
            $display("FAIL frame_counts got de=%0d hs_low=%0d vs_low=%0d expected %0d %0d %0d",
                     de_total - s_de, hs_low_total - s_hs, vs_low_total - s_vs, VA * HA, VT * HS, VS * HT);
        end
        checks++;
        if (de_rise_cyc != fd + FRAME || fcnt !== 8'd1) begin
            errors++;
            $display("FAIL frame_period got period=%0d fcnt=%0d expected %0d 1", de_rise_cyc - fd, fcnt, FRAME);
        end
    endtask

    task automatic test_pattern_switch(output int fd2);
        int cen, fd, n0;
        rst = 1'b1; en = 1'b1; sel = 2'd2;
        sb_q.delete();
        push_frame(2'd2, 8'd0);
        repeat (3) step();
        checks++;
        if (de !== 1'b0 || hs !== 1'b1 || vs !== 1'b1 || fcnt !== 8'd0) begin
            errors++;
            $display("FAIL rst_beats_en got de=%b hs=%b vs=%b fcnt=%0d expected 0 1 1 0", de, hs, vs, fcnt);
        end
        n0 = de_rise_n;
        rst = 1'b0; cen = cyc;
        wait_de_rise(n0, 20, fd);
        checks++;
        if (fd - cen != 2) begin errors++; $display("FAIL restart_latency got=%0d expected=2", fd - cen); end
        wait_cyc(fd + 32);
        checks++;
        if (data !== 32'h00FFFFFF) begin errors++; $display("FAIL checker_x32 got=%h expected=00FFFFFF", data); end
        wait_cyc(fd + 40 * HT);
        sel = 2'd3;
        push_frame(2'd3, 8'd1);
        wait_cyc(fd + FRAME);
        checks++;
        if (data !== 32'h0001FE80 || fcnt !== 8'd1) begin
            errors++;
            $display("FAIL solid_next_frame got data=%h fcnt=%0d expected 0001FE80 1", data, fcnt);
        end
        fd2 = fd + FRAME;
    endtask

    task automatic test_drain(input int fd2);
        int s_de;
        wait_cyc(fd2 + 30 * HT);
        en = 1'b0;
        wait_cyc(fd2 + FRAME + 10);
        checks++;
        if (de !== 1'b0 || hs !== 1'b1 || vs !== 1'b1 || data !== 32'h0 || fcnt !== 8'd2 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain_idle got de=%b hs=%b vs=%b data=%h fcnt=%0d left=%0d expected 0 1 1 0 2 0",
                     de, hs, vs, data, fcnt, sb_q.size());
        end
        s_de = de_total;
        repeat (300) step();
        checks++;
        if (de_total != s_de || fcnt !== 8'd2) begin
            errors++;
            $display("FAIL drain_stays_idle got new_de=%0d fcnt=%0d expected 0 2", de_total - s_de, fcnt);
        end
    endtask

    task automatic test_gradient_and_reset_mid;
        int cen, fd, n0;
        sel = 2'd1;
        push_frame(2'd1, 8'd2);
        n0 = de_rise_n;
        en = 1'b1; cen = cyc;
        wait_de_rise(n0, 20, fd);
        checks++;
        if (fd - cen != 2 || data !== 32'h00000002) begin
            errors++;
            $display("FAIL gradient_start got latency=%0d data=%h expected 2 00000002", fd - cen, data);
        end
        wait_cyc(fd + 5 * HT + 7);
        checks++;
        if (data !== 32'h00070502) begin errors++; $display("FAIL gradient_x7_y5 got=%h expected=00070502", data); end
        wait_cyc(fd + 10 * HT + 29);
        rst = 1'b1;
        sb_q.delete();
        step();
        checks++;
        if (de !== 1'b0 || hs !== 1'b1 || vs !== 1'b1 || data !== 32'h0 || fcnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid got de=%b hs=%b vs=%b data=%h fcnt=%0d expected 0 1 1 0 0", de, hs, vs, data, fcnt);
        end
        step();
        sel = 2'd0;
        push_frame(2'd0, 8'd0);
        n0 = de_rise_n;
        rst = 1'b0; cen = cyc;
        wait_de_rise(n0, 20, fd);
        checks++;
        if (fd - cen != 2 || data !== 32'h00FFFFFF) begin
            errors++;
            $display("FAIL reset_restart got latency=%0d data=%h expected 2 00FFFFFF", fd - cen, data);
        end
        wait_cyc(fd + 2 * HT);
        rst = 1'b1;
        sb_q.delete();
        step();
    endtask

    initial begin
        int fd2;
        rst = 1'b1; en = 1'b0; sel = 2'd0;
        step();
        test_reset();
        test_bars();
        test_pattern_switch(fd2);
        test_drain(fd2);
        test_gradient_and_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
